regfile_wb_scheduler: RTL

//  Shares the single register_bank write port (RegWrite / write address / write data) among
//  NUM_REQ writeback requesters (ALU, load, mul ...) with round-robin arbitration.

---
 rtl/regbank_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 43 ++++
 rtl/regfile_wb_scheduler.sv | 114 +++++++++++
 3 files changed

// File: rtl/regbank_pkg.sv
// Shared register-bank constants and types for the writeback path.
package regbank_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [XLEN-1:0]       xlen_t;
  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last winner,
// wrapping, and remembers the winner whenever a grant is given.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr_q;
  logic          any_grant;

  // Scan requesters starting just after the last winner and pick the first one asking.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int cand;
      cand = (int'(ptr_q) + k) % N;
      if (!any_grant && req[cand]) begin
        any_grant   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
  end

  // The winner becomes the lowest priority next time; reset leaves requester 0 first in line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= IW'(N - 1);
    end else if (any_grant) begin
      ptr_q <= grant_idx;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler: shares the single register-bank write port among the
// writeback sources and keeps the busy scoreboard used for RAW stalls.
module regfile_wb_scheduler
  import regbank_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*XLEN-1:0]       req_data,
  input  logic                          issue_valid,
  input  logic [REG_ADDR_W-1:0]         issue_rd,
  output logic                          issue_ready,
  input  logic [REG_ADDR_W-1:0]         rs1_addr,
  input  logic [REG_ADDR_W-1:0]         rs2_addr,
  output logic                          rs1_busy,
  output logic                          rs2_busy,
  output logic                          wr_en,
  output logic [REG_ADDR_W-1:0]         wr_addr,
  output logic [XLEN-1:0]               wr_data,
  output logic                          sb_err
);

  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]  grant;
  logic [GW-1:0]       grant_idx;
  logic                handshake;
  logic                wb_fire;
  reg_idx_t            sel_rd;
  xlen_t               sel_data;

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                wr_en_q;
  reg_idx_t            wr_addr_q;
  xlen_t               wr_data_q;
  logic                sb_err_q;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign handshake = |grant;
  assign sel_rd    = req_rd[int'(grant_idx)*REG_ADDR_W +: REG_ADDR_W];
  assign sel_data  = req_data[int'(grant_idx)*XLEN +: XLEN];
  // Writes to x0 still handshake but never reach the bank or the scoreboard.
  assign wb_fire   = handshake && (sel_rd != '0);

  // A busy destination may still issue if it is being written back on this very edge.
  assign issue_ready = !busy_q[issue_rd] || (wr_en_q && (wr_addr_q == issue_rd)) || (issue_rd == '0);

  assign rs1_busy = busy_q[rs1_addr];
  assign rs2_busy = busy_q[rs2_addr];

  // Next scoreboard: clear the register the bank writes now, then apply a new issue so a same-index issue wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q) begin
      busy_d[wr_addr_q] = 1'b0;
    end
    if (issue_valid && issue_ready && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Write stage: one cycle after a handshake the bank sees the write; address and data hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= wb_fire;
      if (wb_fire) begin
        wr_addr_q <= sel_rd;
        wr_data_q <= sel_data;
      end
    end
  end

  // Sticky error when a result arrives for a register nobody marked busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_err_q <= 1'b0;
    end else if (wb_fire && !busy_q[sel_rd]) begin
      sb_err_q <= 1'b1;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign sb_err  = sb_err_q;

endmodule
